// File: rtl/proc_io_pkg.sv
// proc_io_pkg: shared types and constants for the processor I/O endpoint.
//   PROC_IO_DATA_W : default processor port width
//   drv_state_e    : drive-path FSM states (IDLE, HOLD)
//   cap_entry_t    : capture FIFO entry layout at the default width
// Optional feature macro: PROC_IO_TIMESTAMP_EN adds a timestamp field to
// cap_entry_t.
package proc_io_pkg;

  localparam int unsigned PROC_IO_DATA_W = 32;

  typedef enum logic [0:0] {
    DRV_IDLE = 1'b0,
    DRV_HOLD = 1'b1
  } drv_state_e;

  // Entry layout at the default width. The endpoint packs the same layout
  // into a flat vector so that a non-default DATA_W still works.
  typedef struct packed {
`ifdef PROC_IO_TIMESTAMP_EN
    logic [PROC_IO_DATA_W-1:0] ts;
`endif
    logic [PROC_IO_DATA_W-1:0] data;
  } cap_entry_t;

endpackage

// File: rtl/proc_io_fifo.sv
// proc_io_fifo: synchronous show-ahead FIFO with occupancy count and
// drop-on-full. A push while full is accepted only when a pop happens in the
// same cycle; otherwise the word is dropped and overflow_o sets until reset.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   push_i/wdata_i: write request and data
//   pop_i         : read request (ignored while empty)
//   rdata_o       : head entry (valid when valid_o)
//   valid_o       : FIFO non-empty
//   count_o       : occupancy, 0..DEPTH
//   overflow_o    : sticky drop indicator
module proc_io_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          valid_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          empty_s, full_s, pop_s, push_s;

  // Push/pop qualification and next-state pointers/count.
  always_comb begin
    empty_s  = (count_q == '0);
    full_s   = (count_q == FULL_CNT);
    pop_s    = pop_i && !empty_s;
    // When full, a same-cycle pop frees the slot the write lands in.
    push_s   = push_i && (!full_s || pop_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (push_i && !push_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pointer, count and overflow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are don't-care until written, pointers gate reads.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign valid_o    = !empty_s;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/proc_io_endpoint.sv
// proc_io_endpoint: host-side endpoint for the processor data_in/data_out pair.
//   Capture: every change on proc_data_out (and the first sample after
//   reset) is pushed into a show-ahead FIFO drained over cap_valid/cap_ready.
//   Drive: host words accepted on drv_valid/drv_ready are held on
//   proc_data_in for HOLD_CYCLES cycles; otherwise proc_data_in carries a
//   free-running cycle count.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   proc_data_out       : sampled processor output
//   proc_data_in        : registered drive to processor input
//   cap_valid/cap_data  : FIFO head, show-ahead
//   cap_ready           : host pop
//   cap_count           : FIFO occupancy
//   cap_overflow        : sticky capture-drop flag
//   drv_valid/drv_data  : host word in
//   drv_ready           : endpoint accepts drv_data
//   cap_ts              : head timestamp (only with PROC_IO_TIMESTAMP_EN)
// Optional feature macro: PROC_IO_TIMESTAMP_EN.
module proc_io_endpoint
  import proc_io_pkg::*;
#(
  parameter int unsigned DATA_W      = PROC_IO_DATA_W,
  parameter int unsigned CAP_DEPTH   = 8,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            proc_data_out,
  output logic [DATA_W-1:0]            proc_data_in,
  output logic                         cap_valid,
  output logic [DATA_W-1:0]            cap_data,
  input  logic                         cap_ready,
  output logic [$clog2(CAP_DEPTH):0]   cap_count,
  output logic                         cap_overflow,
`ifdef PROC_IO_TIMESTAMP_EN
  output logic [DATA_W-1:0]            cap_ts,
`endif
  input  logic                         drv_valid,
  input  logic [DATA_W-1:0]            drv_data,
  output logic                         drv_ready
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;
`ifdef PROC_IO_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = 2 * DATA_W;
`else
  localparam int unsigned ENTRY_W = DATA_W;
`endif

  logic [DATA_W-1:0]  cycle_cnt_q;
  logic [DATA_W-1:0]  last_out_q;
  logic               first_q;
  drv_state_e         state_q, state_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]  proc_data_in_q, proc_data_in_d;
  logic               drv_ready_s, accept_s;
  logic               push_s;
  logic [ENTRY_W-1:0] push_entry_s, head_entry_s;

  // Cycle counter and capture change-detection state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
      last_out_q  <= '0;
      first_q     <= 1'b1;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + DATA_W'(1);
      last_out_q  <= proc_data_out;
      first_q     <= 1'b0;
    end
  end

  assign push_s = first_q || (proc_data_out != last_out_q);

`ifdef PROC_IO_TIMESTAMP_EN
  assign push_entry_s = {cycle_cnt_q, proc_data_out};
  assign cap_ts       = head_entry_s[ENTRY_W-1:DATA_W];
`else
  assign push_entry_s = proc_data_out;
`endif
  assign cap_data = head_entry_s[DATA_W-1:0];

  proc_io_fifo #(
    .W     (ENTRY_W),
    .DEPTH (CAP_DEPTH)
  ) u_cap_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_s),
    .wdata_i    (push_entry_s),
    .pop_i      (cap_ready),
    .rdata_o    (head_entry_s),
    .valid_o    (cap_valid),
    .count_o    (cap_count),
    .overflow_o (cap_overflow)
  );

  // Drive FSM next state and proc_data_in next value.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    proc_data_in_d = proc_data_in_q;
    // Ready again in the last HOLD cycle so back-to-back words have no gap.
    drv_ready_s    = rst && ((state_q == DRV_IDLE) || (hold_cnt_q == '0));
    accept_s       = drv_valid && drv_ready_s;
    if (accept_s) begin
      state_d        = DRV_HOLD;
      hold_cnt_d     = HW'(HOLD_CYCLES - 1);
      proc_data_in_d = drv_data;
    end else begin
      case (state_q)
        DRV_IDLE: begin
          proc_data_in_d = cycle_cnt_q;
        end
        DRV_HOLD: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HW'(1);
          end else begin
            state_d        = DRV_IDLE;
            proc_data_in_d = cycle_cnt_q;
          end
        end
        default: begin
          state_d        = DRV_IDLE;
          proc_data_in_d = cycle_cnt_q;
        end
      endcase
    end
  end

  // Drive FSM and output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= DRV_IDLE;
      hold_cnt_q     <= '0;
      proc_data_in_q <= '0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      proc_data_in_q <= proc_data_in_d;
    end
  end

  assign proc_data_in = proc_data_in_q;
  assign drv_ready    = drv_ready_s;

endmodule

// File: tb/tb_proc_io_endpoint.sv
// Directed testbench for proc_io_endpoint at default parameters
// (DATA_W=32, CAP_DEPTH=8, HOLD_CYCLES=2).
module tb_proc_io_endpoint;

  logic        clk;
  logic        rst;
  logic [31:0] proc_data_out;
  logic [31:0] proc_data_in;
  logic        cap_valid;
  logic [31:0] cap_data;
  logic        cap_ready;
  logic [3:0]  cap_count;
  logic        cap_overflow;
`ifdef PROC_IO_TIMESTAMP_EN
  logic [31:0] cap_ts;
`endif
  logic        drv_valid;
  logic [31:0] drv_data;
  logic        drv_ready;

  int          n_total;
  int          n_pass;
  logic [31:0] cyc;

  proc_io_endpoint dut (
    .clk           (clk),
    .rst           (rst),
    .proc_data_out (proc_data_out),
    .proc_data_in  (proc_data_in),
    .cap_valid     (cap_valid),
    .cap_data      (cap_data),
    .cap_ready     (cap_ready),
    .cap_count     (cap_count),
    .cap_overflow  (cap_overflow),
`ifdef PROC_IO_TIMESTAMP_EN
    .cap_ts        (cap_ts),
`endif
    .drv_valid     (drv_valid),
    .drv_data      (drv_data),
    .drv_ready     (drv_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; cyc mirrors the expected DUT cycle counter after the edge.
  task automatic step();
    @(posedge clk);
    if (rst) cyc = cyc + 32'd1;
    else     cyc = 32'd0;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    cyc     = 32'd0;
    rst           = 1'b0;
    proc_data_out = 32'h5;
    cap_ready     = 1'b0;
    drv_valid     = 1'b0;
    drv_data      = 32'h0;

    // 1. Reset entry and release.
    step(); step(); step();
    chk("rst_pdi", 64'(proc_data_in), 64'h0);
    chk("rst_cap_valid", 64'(cap_valid), 64'h0);
    chk("rst_drv_ready", 64'(drv_ready), 64'h0);
    chk("rst_cap_count", 64'(cap_count), 64'h0);
    chk("rst_overflow", 64'(cap_overflow), 64'h0);
    rst = 1'b1;
    #1;
    chk("rel_drv_ready", 64'(drv_ready), 64'h1);
    step();
    chk("rel_cap_valid", 64'(cap_valid), 64'h1);
    chk("rel_cap_data", 64'(cap_data), 64'h5);
    chk("rel_cap_count", 64'(cap_count), 64'h1);
    chk("rel_pdi0", 64'(proc_data_in), 64'h0);
    step();
    chk("nochg_count", 64'(cap_count), 64'h1);
    chk("idle_pdi1", 64'(proc_data_in), 64'h1);
    cap_ready = 1'b1;
    step();
    cap_ready = 1'b0;
    chk("pop_empty", 64'(cap_valid), 64'h0);

    // 2. Change detection.
    proc_data_out = 32'h1; step(); step(); step();
    proc_data_out = 32'h2; step();
    chk("chg_count", 64'(cap_count), 64'h2);
    chk("chg_head0", 64'(cap_data), 64'h1);
    cap_ready = 1'b1;
    step();
    chk("chg_head1", 64'(cap_data), 64'h2);
    step();
    cap_ready = 1'b0;
    chk("chg_drained", 64'(cap_count), 64'h0);

    // 3. Overflow: 10 distinct values into 8 entries.
    for (int i = 0; i < 10; i++) begin
      proc_data_out = 32'h100 + 32'(i);
      step();
    end
    chk("ovf_count", 64'(cap_count), 64'h8);
    chk("ovf_flag", 64'(cap_overflow), 64'h1);
    cap_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", 64'(cap_data), 64'(32'h100 + 32'(i)));
      step();
    end
    cap_ready = 1'b0;
    chk("ovf_drained", 64'(cap_count), 64'h0);
    chk("ovf_sticky", 64'(cap_overflow), 64'h1);

    // 4. Full push+pop after a clearing reset.
    rst = 1'b0;
    proc_data_out = 32'h200;
    step();
    chk("rst2_overflow", 64'(cap_overflow), 64'h0);
    chk("rst2_count", 64'(cap_count), 64'h0);
    rst = 1'b1;
    step();
    for (int i = 1; i < 8; i++) begin
      proc_data_out = 32'h200 + 32'(i);
      step();
    end
    chk("full_count", 64'(cap_count), 64'h8);
    chk("full_head", 64'(cap_data), 64'h200);
    proc_data_out = 32'h208;
    cap_ready = 1'b1;
    step();
    cap_ready = 1'b0;
    chk("pp_count", 64'(cap_count), 64'h8);
    chk("pp_overflow", 64'(cap_overflow), 64'h0);
    chk("pp_head", 64'(cap_data), 64'h201);
    cap_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      chk("pp_drain", 64'(cap_data), 64'(32'h200 + 32'(i)));
      step();
    end
    cap_ready = 1'b0;
    chk("pp_drained", 64'(cap_valid), 64'h0);

    // 5. Back-to-back drive.
    drv_data  = 32'hDEADBEEF;
    drv_valid = 1'b1;
    step();
    chk("drv_a0", 64'(proc_data_in), 64'hDEADBEEF);
    chk("drv_a0_ready", 64'(drv_ready), 64'h0);
    drv_data = 32'hCAFEF00D;
    step();
    chk("drv_a1", 64'(proc_data_in), 64'hDEADBEEF);
    chk("drv_a1_ready", 64'(drv_ready), 64'h1);
    step();
    drv_valid = 1'b0;
    chk("drv_b0", 64'(proc_data_in), 64'hCAFEF00D);
    step();
    chk("drv_b1", 64'(proc_data_in), 64'hCAFEF00D);
    step();
    chk("drv_idle0", 64'(proc_data_in), 64'(cyc - 32'd1));
    step();
    chk("drv_idle1", 64'(proc_data_in), 64'(cyc - 32'd1));

    // 6. Reset mid-HOLD with a full, overflowed FIFO.
    for (int i = 0; i < 10; i++) begin
      proc_data_out = 32'h300 + 32'(i);
      step();
    end
    chk("pre6_overflow", 64'(cap_overflow), 64'h1);
    drv_data  = 32'h12345678;
    drv_valid = 1'b1;
    step();
    drv_valid = 1'b0;
    chk("hold_word", 64'(proc_data_in), 64'h12345678);
    rst = 1'b0;
    #1;
    chk("midrst_drv_ready", 64'(drv_ready), 64'h0);
    step();
    chk("midrst_pdi", 64'(proc_data_in), 64'h0);
    chk("midrst_count", 64'(cap_count), 64'h0);
    chk("midrst_overflow", 64'(cap_overflow), 64'h0);
    rst = 1'b1;
    #1;
    chk("post_drv_ready", 64'(drv_ready), 64'h1);
    step();
    chk("post_pdi0", 64'(proc_data_in), 64'h0);
    step();
    chk("post_pdi1", 64'(proc_data_in), 64'h1);
    step();
    chk("post_pdi2", 64'(proc_data_in), 64'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
